fp_align_stage: RTL and testbench
=================================

Name: fp_align_stage

Overview:
- Pipelined FP32 add/sub operand-alignment stage, directly upstream of the 24-bit right barrel shifter (n=24, sel=5) in the FPU execute slot.
- Unpacks two operands, orders them by magnitude, computes the clamped exponent difference, and presents big/small mantissas plus shift amount.
- The shifter consumes small_mant/shift_amt combinationally.
- 2-stage valid/ready pipeline, throughput 1 op/cycle.

Parameters:
- EXP_W, 8, exponent width.
- MAN_W, 23, stored fraction width. Mantissa with hidden bit = MAN_W+1 = 24.
- SHIFT_W, 5, shift-amount width. Must satisfy 2**SHIFT_W >= MAN_W+1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  stage can accept.
- op_a  in  32  IEEE-754 single, operand A.
- op_b  in  32  IEEE-754 single, operand B.
- op_sub  in  1  1 = A-B, 0 = A+B.
- out_valid  out  1  aligned result valid.
- out_ready  in  1  downstream accepts.
- big_mant  out  24  larger-magnitude mantissa incl. hidden bit.
- small_mant  out  24  smaller-magnitude mantissa, unshifted, to shifter input.
- shift_amt  out  5  right-shift for small_mant, saturated.
- exp_big  out  8  exponent of larger operand.
- sign_big  out  1  sign of larger operand (B's sign pre-inverted if op_sub).
- eff_sub  out  1  effective subtraction = sA ^ sB ^ op_sub.
- swapped  out  1  1 when B is the larger operand.
- shift_sat  out  1  exponent difference exceeded 2**SHIFT_W-1.
- special  out  2  00 normal, 01 result NaN, 10 result Inf, 11 both operands zero.
- sticky  out  1  see Optional Feature.

Behaviour:
- Clock and reset: single clock clk; rst asynchronous active-high. All pipeline valids and every output register clear to 0 on rst assertion, independent of clk. in_ready = 1 one cycle after rst deasserts. Reset mid-operation discards both in-flight ops; no output handshake occurs for them.
- Stage 1 (S1), captured on in_valid && in_ready:
  - Unpack operands; effective sign of B = sB ^ op_sub.
  - Denormals flush to zero: exp==0 gives mant=0 and is treated as zero.
  - Hidden bit = (exp != 0).
  - Register unpacked fields and magnitude compare: {exp, frac}.
- Stage 2 (S2), captured when S1 advances:
  - Select big/small by magnitude. Tie (equal magnitude) -> A is big, swapped=0.
  - diff = exp_big - exp_small, unsigned, 8 bits.
  - shift_amt = diff if diff <= 31, else 31 with shift_sat=1.
  - Shifts 24..31 zero the shifter output; this is legal.
- special:
  - Either operand NaN (exp=FF, frac!=0) -> 01.
  - Inf - Inf under eff_sub -> 01.
  - Otherwise any Inf -> 10.
  - Both operands zero -> 11.
  - Mantissa outputs stay computed normally in all cases; downstream overrides.
- Handshake:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || (s2_adv).
  - in_ready = s1_adv.
  - out_valid = s2_valid.
  - Outputs hold stable while out_valid && !out_ready.
  - No combinational path in_valid -> out_valid. in_ready depends combinationally on out_ready only.
- Latency: 2 cycles from accept to out_valid with no backpressure. Full throughput under continuous out_ready=1.
- Full pipe (both stages valid, out_ready=0): in_ready=0, no data loss, no duplication. When out_ready and in_valid are both high on a full pipe, one op retires and one enters in the same cycle.

Optional Feature:
- Macro FP_ALIGN_STICKY_EN.
- Defined: S2 computes sticky = OR of small_mant bits [shift_amt-1:0]; saturated shift -> OR of all 24 bits. sticky is registered with the other S2 outputs.
- Undefined: sticky tied 0, no logic generated. Port is always present.

Decomposition:
- Shared package fp_pkg holds:
  - Constants EXP_W, MAN_W, EXP_MAX=8'hFF.
  - Special-code encodings SPC_NONE/SPC_NAN/SPC_INF/SPC_ZERO.
  - Unpacked-operand typedef {sign, exp, mant[23:0], is_zero, is_inf, is_nan}.
- One sub-module, fp_unpack: combinational field extract, hidden bit, and class flags. Instantiated twice in S1.

Test Plan:
- A=0x3F800000, B=0x3F000000, add -> after 2 cycles: big_mant=0x800000, small_mant=0x800000, shift_amt=1, exp_big=0x7F, swapped=0, eff_sub=0, special=00.
- A=0x3F000000, B=0xBF800000, add -> swapped=1, sign_big=1, eff_sub=1, shift_amt=1. Equal-magnitude A=B=0x40000000 with sub -> swapped=0, shift_amt=0, eff_sub=1.
- A=0x3F800000, B=0x2B800000 (diff 40) -> shift_amt=31, shift_sat=1. With FP_ALIGN_STICKY_EN defined, sticky=1.
- A=0x7F800000, B=0x7F800000, sub -> special=01. A=0x7FC00000 -> special=01. A=0x00000001, B=0x00000000 -> special=11 (denormal flushed).
- Backpressure: issue 4 back-to-back ops with out_ready=0 for 5 cycles. Required: in_ready drops after 2 accepts; outputs stable; on release all 4 ops emerge in order, no drops or duplicates.
- rst pulsed asynchronously mid-cycle with both stages valid -> out_valid=0 immediately. Next accepted op appears exactly 2 cycles after accept.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared FP32 definitions for the add/sub alignment stage: field widths,
// special-result codes and the unpacked-operand record.
package fp_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef enum logic [1:0] {
    SPC_NONE = 2'b00,
    SPC_NAN  = 2'b01,
    SPC_INF  = 2'b10,
    SPC_ZERO = 2'b11
  } spc_e;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W:0]   mant;
    logic             is_zero;
    logic             is_inf;
    logic             is_nan;
  } unpacked_t;

  // Result class of the pair; eff_sub decides whether Inf-Inf cancels to NaN.
  function automatic spc_e classify(input unpacked_t a, input unpacked_t b,
                                    input logic eff_sub);
    spc_e code;
    code = SPC_NONE;
    if (a.is_nan || b.is_nan) begin
      code = SPC_NAN;
    end else if (a.is_inf && b.is_inf && eff_sub) begin
      code = SPC_NAN;
    end else if (a.is_inf || b.is_inf) begin
      code = SPC_INF;
    end else if (a.is_zero && b.is_zero) begin
      code = SPC_ZERO;
    end
    return code;
  endfunction

endpackage

// File: rtl/fp_unpack.sv
// Combinational FP32 field extraction with hidden bit, denormal flush-to-zero
// and class flags. flip inverts the sign (used for B under subtraction).
module fp_unpack
  import fp_pkg::*;
(
  input  logic [EXP_W+MAN_W:0] word,
  input  logic                 flip,
  output unpacked_t            fields
);

  logic [EXP_W-1:0] exp_field;
  logic [MAN_W-1:0] frac_field;
  logic             hidden;

  assign exp_field  = word[EXP_W+MAN_W-1:MAN_W];
  assign frac_field = word[MAN_W-1:0];
  assign hidden     = (exp_field != '0);

  always_comb begin
    fields         = '0;
    fields.sign    = word[EXP_W+MAN_W] ^ flip;
    fields.exp     = exp_field;
    // Denormals carry no mantissa: exponent zero means the value is zero.
    fields.mant    = hidden ? {1'b1, frac_field} : '0;
    fields.is_zero = !hidden;
    fields.is_inf  = (exp_field == EXP_MAX) && (frac_field == '0);
    fields.is_nan  = (exp_field == EXP_MAX) && (frac_field != '0);
  end

endmodule

// File: rtl/fp_align_stage.sv
// Two-stage FP32 add/sub operand alignment feeding the right barrel shifter.
// Optional sticky generation is enabled by defining FP_ALIGN_STICKY_EN.
module fp_align_stage #(
  parameter int EXP_W   = 8,
  parameter int MAN_W   = 23,
  parameter int SHIFT_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] op_a,
  input  logic [EXP_W+MAN_W:0] op_b,
  input  logic                 op_sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [MAN_W:0]       big_mant,
  output logic [MAN_W:0]       small_mant,
  output logic [SHIFT_W-1:0]   shift_amt,
  output logic [EXP_W-1:0]     exp_big,
  output logic                 sign_big,
  output logic                 eff_sub,
  output logic                 swapped,
  output logic                 shift_sat,
  output logic [1:0]           special,
  output logic                 sticky
);

  import fp_pkg::*;

  localparam logic [EXP_W-1:0] SHIFT_MAX = EXP_W'((1 << SHIFT_W) - 1);

  logic      init_reg;
  logic      s1_valid;
  logic      s2_valid;
  logic      s1_adv;
  logic      s2_adv;

  unpacked_t ua;
  unpacked_t ub;
  logic      b_big;

  unpacked_t s1_a;
  unpacked_t s1_b;
  logic      s1_b_big;
  logic      s1_eff_sub;
  logic      s1_op_sub_unused;

  unpacked_t        big_sel;
  unpacked_t        small_sel;
  logic [EXP_W-1:0] diff;
  logic             sat_next;
  logic [SHIFT_W-1:0] shift_next;
  spc_e             spc_next;

  // ---------------------------------------------------------------- handshake
  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  // init_reg holds off acceptance until the first clock after reset release.
  assign in_ready  = s1_adv && init_reg;
  assign out_valid = s2_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_reg <= 1'b0;
    end else begin
      init_reg <= 1'b1;
    end
  end

  // ------------------------------------------------------------------ stage 1
  fp_unpack u_unpack_a (
    .word   (op_a),
    .flip   (1'b0),
    .fields (ua)
  );

  fp_unpack u_unpack_b (
    .word   (op_b),
    .flip   (op_sub),
    .fields (ub)
  );

  // Flushed mantissa keeps denormals at magnitude zero in the compare.
  assign b_big = {ub.exp, ub.mant[MAN_W-1:0]} > {ua.exp, ua.mant[MAN_W-1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_b_big   <= 1'b0;
      s1_eff_sub <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid && init_reg;
      end
      if (in_valid && in_ready) begin
        s1_a       <= ua;
        s1_b       <= ub;
        s1_b_big   <= b_big;
        s1_eff_sub <= ua.sign ^ ub.sign;
      end
    end
  end

  assign s1_op_sub_unused = 1'b0;

  // ------------------------------------------------------------------ stage 2
  always_comb begin
    big_sel    = s1_b_big ? s1_b : s1_a;
    small_sel  = s1_b_big ? s1_a : s1_b;
    diff       = big_sel.exp - small_sel.exp;
    sat_next   = diff > SHIFT_MAX;
    shift_next = sat_next ? {SHIFT_W{1'b1}} : diff[SHIFT_W-1:0];
    spc_next   = classify(s1_a, s1_b, s1_eff_sub);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid   <= 1'b0;
      big_mant   <= '0;
      small_mant <= '0;
      shift_amt  <= '0;
      exp_big    <= '0;
      sign_big   <= 1'b0;
      eff_sub    <= 1'b0;
      swapped    <= 1'b0;
      shift_sat  <= 1'b0;
      special    <= SPC_NONE;
    end else begin
      if (s2_adv) begin
        s2_valid <= s1_valid;
      end
      if (s2_adv && s1_valid) begin
        big_mant   <= big_sel.mant;
        small_mant <= small_sel.mant;
        shift_amt  <= shift_next;
        exp_big    <= big_sel.exp;
        sign_big   <= big_sel.sign;
        eff_sub    <= s1_eff_sub;
        swapped    <= s1_b_big;
        shift_sat  <= sat_next;
        special    <= spc_next;
      end
    end
  end

`ifdef FP_ALIGN_STICKY_EN
  localparam logic [MAN_W:0] MANT_ONE = {{MAN_W{1'b0}}, 1'b1};

  logic [MAN_W:0] sticky_mask;
  logic           sticky_next;

  // Shifts of MAN_W+1 or more wrap the one-hot to zero, so the mask goes all-ones.
  always_comb begin
    sticky_mask = sat_next ? {(MAN_W+1){1'b1}} : ((MANT_ONE << shift_next) - MANT_ONE);
    sticky_next = |(small_sel.mant & sticky_mask);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky <= 1'b0;
    end else if (s2_adv && s1_valid) begin
      sticky <= sticky_next;
    end
  end
`else
  assign sticky = 1'b0;
`endif

endmodule

// File: tb/tb_fp_align_stage.sv
// Self-checking bench for fp_align_stage: behavioural model plus scoreboard,
// directed vectors with literal expectations, backpressure and reset cases.
module tb_fp_align_stage;

`ifdef FP_ALIGN_STICKY_EN
  localparam bit STK_EN = 1'b1;
`else
  localparam bit STK_EN = 1'b0;
`endif

  typedef struct packed {
    logic [23:0] bm;
    logic [23:0] sm;
    logic [4:0]  sh;
    logic [7:0]  eb;
    logic        sb;
    logic        es;
    logic        sw;
    logic        sat;
    logic [1:0]  spc;
    logic        stk;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        op_sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [23:0] big_mant;
  logic [23:0] small_mant;
  logic [4:0]  shift_amt;
  logic [7:0]  exp_big;
  logic        sign_big;
  logic        eff_sub;
  logic        swapped;
  logic        shift_sat;
  logic [1:0]  special;
  logic        sticky;

  res_t dut_r;
  res_t exp_q[$];
  res_t hold_r;
  bit   hold_v = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_accept = 0;
  int   n_retire = 0;
  int   cyc = 0;

  fp_align_stage dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .op_sub     (op_sub),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .big_mant   (big_mant),
    .small_mant (small_mant),
    .shift_amt  (shift_amt),
    .exp_big    (exp_big),
    .sign_big   (sign_big),
    .eff_sub    (eff_sub),
    .swapped    (swapped),
    .shift_sat  (shift_sat),
    .special    (special),
    .sticky     (sticky)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign dut_r = {big_mant, small_mant, shift_amt, exp_big, sign_big, eff_sub,
                  swapped, shift_sat, special, sticky};

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Reference from the arithmetic definition: magnitudes, exponent gap, classes.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    res_t        r;
    int          ea, eb, eB, eS, diff;
    int unsigned ma, mb, maga, magb, mB, mS;
    bit          sa, sbv, bbig, nan_a, nan_b, inf_a, inf_b;
    ea   = int'(a[30:23]);
    eb   = int'(b[30:23]);
    ma   = (ea == 0) ? 0 : ((32'd1 << 23) + a[22:0]);
    mb   = (eb == 0) ? 0 : ((32'd1 << 23) + b[22:0]);
    maga = (ea == 0) ? 0 : a[30:0];
    magb = (eb == 0) ? 0 : b[30:0];
    sa   = a[31];
    sbv  = b[31] ^ s;
    bbig = magb > maga;
    eB   = bbig ? eb : ea;
    eS   = bbig ? ea : eb;
    mB   = bbig ? mb : ma;
    mS   = bbig ? ma : mb;
    diff = eB - eS;
    r.bm  = mB[23:0];
    r.sm  = mS[23:0];
    r.sh  = (diff > 31) ? 5'd31 : 5'(diff);
    r.sat = diff > 31;
    r.eb  = 8'(eB);
    r.sb  = bbig ? sbv : sa;
    r.es  = sa ^ sbv;
    r.sw  = bbig;
    if (!STK_EN) r.stk = 1'b0;
    else if (diff >= 24) r.stk = (mS != 0);
    else r.stk = (mS % (32'd1 << diff)) != 0;
    nan_a = (ea == 255) && (a[22:0] != 0);
    nan_b = (eb == 255) && (b[22:0] != 0);
    inf_a = (ea == 255) && (a[22:0] == 0);
    inf_b = (eb == 255) && (b[22:0] == 0);
    if (nan_a || nan_b) r.spc = 2'b01;
    else if (inf_a && inf_b && r.es) r.spc = 2'b01;
    else if (inf_a || inf_b) r.spc = 2'b10;
    else if (ea == 0 && eb == 0) r.spc = 2'b11;
    else r.spc = 2'b00;
    return r;
  endfunction

  function automatic res_t lit(input logic [23:0] bm, input logic [23:0] sm, input logic [4:0] sh,
                               input logic [7:0] eb, input logic sb, input logic es, input logic sw,
                               input logic sat, input logic [1:0] spc, input logic stk_if_en);
    res_t r;
    r = {bm, sm, sh, eb, sb, es, sw, sat, spc, STK_EN ? stk_if_en : 1'b0};
    return r;
  endfunction

  // Scoreboard / compare process: all samples on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (hold_v) begin
        check("hold_valid", 128'(out_valid), 128'd1);
        check("hold_data", 128'(dut_r), 128'(hold_r));
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 128'd1, 128'd0);
        end else begin
          check("model", 128'(dut_r), 128'(exp_q[0]));
          if (out_ready) begin
            void'(exp_q.pop_front());
            n_retire++;
          end
        end
      end
      hold_v = out_valid && !out_ready;
      hold_r = dut_r;
      if (in_valid && in_ready) begin
        exp_q.push_back(model(op_a, op_b, op_sub));
        n_accept++;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s);
    int w;
    op_a = a;
    op_b = b;
    op_sub = s;
    in_valid = 1'b1;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!in_ready && w < 50);
    if (!in_ready) check("accept_timeout", 128'd0, 128'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic expect_lit(input string name, input res_t req);
    int w;
    in_valid = 1'b0;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!out_valid && w < 10);
    if (!out_valid) check({name, "_timeout"}, 128'd0, 128'd1);
    else check(name, 128'(dut_r), 128'(req));
    @(posedge clk);
    #1;
  endtask

  task automatic one(input string name, input logic [31:0] a, input logic [31:0] b,
                     input logic s, input res_t req);
    send(a, b, s);
    expect_lit(name, req);
  endtask

  initial begin
    int c0, base_a, base_r, w;
    #12;
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_in_ready", 128'(in_ready), 128'd0);
    check("rst_data", 128'(dut_r), 128'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    check("init_in_ready", 128'(in_ready), 128'd1);

    one("v_add_basic", 32'h3F800000, 32'h3F000000, 1'b0,
        lit(24'h800000, 24'h800000, 5'd1, 8'h7F, 0, 0, 0, 0, 2'b00, 0));
    one("v_swap", 32'h3F000000, 32'hBF800000, 1'b0,
        lit(24'h800000, 24'h800000, 5'd1, 8'h7F, 1, 1, 1, 0, 2'b00, 0));
    one("v_tie_sub", 32'h40000000, 32'h40000000, 1'b1,
        lit(24'h800000, 24'h800000, 5'd0, 8'h80, 0, 1, 0, 0, 2'b00, 0));
    one("v_diff40", 32'h3F800000, 32'h2B800000, 1'b0,
        lit(24'h800000, 24'h800000, 5'd31, 8'h7F, 0, 0, 0, 1, 2'b00, 1));
    one("v_diff31", 32'h3F800000, 32'h30000000, 1'b0,
        lit(24'h800000, 24'h800000, 5'd31, 8'h7F, 0, 0, 0, 0, 2'b00, 1));
    one("v_diff32", 32'h3F800000, 32'h2F800000, 1'b0,
        lit(24'h800000, 24'h800000, 5'd31, 8'h7F, 0, 0, 0, 1, 2'b00, 1));
    one("v_sticky1", 32'h41000000, 32'h3FC00001, 1'b0,
        lit(24'h800000, 24'hC00001, 5'd3, 8'h82, 0, 0, 0, 0, 2'b00, 1));
    one("v_sticky0", 32'h41000000, 32'h3FC00008, 1'b0,
        lit(24'h800000, 24'hC00008, 5'd3, 8'h82, 0, 0, 0, 0, 2'b00, 0));
    one("v_inf_sub_inf", 32'h7F800000, 32'h7F800000, 1'b1,
        lit(24'h800000, 24'h800000, 5'd0, 8'hFF, 0, 1, 0, 0, 2'b01, 0));
    one("v_nan", 32'h7FC00000, 32'h3F800000, 1'b0,
        lit(24'hC00000, 24'h800000, 5'd31, 8'hFF, 0, 0, 0, 1, 2'b01, 1));
    one("v_inf", 32'h3F800000, 32'hFF800000, 1'b0,
        lit(24'h800000, 24'h800000, 5'd31, 8'hFF, 1, 1, 1, 1, 2'b10, 1));
    one("v_zero", 32'h00000001, 32'h00000000, 1'b0,
        lit(24'h000000, 24'h000000, 5'd0, 8'h00, 0, 0, 0, 0, 2'b11, 0));

    // Continuous stream: one accept per cycle with out_ready held high.
    c0 = cyc;
    send(32'h40490FDB, 32'h3F800000, 1'b0);
    send(32'hC0000000, 32'h40400000, 1'b1);
    send(32'h3DCCCCCD, 32'h3E4CCCCD, 1'b0);
    send(32'h42C80000, 32'hC2C80000, 1'b0);
    send(32'h00400000, 32'h3F800000, 1'b1);
    send(32'h7F7FFFFF, 32'h00800000, 1'b0);
    in_valid = 1'b0;
    check("throughput_cycles", 128'(cyc - c0), 128'd6);
    repeat (4) @(posedge clk);
    #1;

    // Backpressure: four ops against a stalled output.
    base_a = n_accept;
    base_r = n_retire;
    out_ready = 1'b0;
    fork
      begin
        send(32'h3F800000, 32'h3F000000, 1'b0);
        send(32'h40000000, 32'h3F800000, 1'b1);
        send(32'h40400000, 32'hC0800000, 1'b0);
        send(32'h41200000, 32'h3C23D70A, 1'b1);
        in_valid = 1'b0;
      end
      begin
        repeat (5) @(negedge clk);
        check("bp_in_ready", 128'(in_ready), 128'd0);
        check("bp_accepts", 128'(n_accept - base_a), 128'd2);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    w = 0;
    while ((n_retire - base_r) < 4 && w < 20) begin
      @(posedge clk);
      w++;
    end
    #1;
    check("bp_retired", 128'(n_retire - base_r), 128'd4);
    check("bp_queue_empty", 128'(exp_q.size()), 128'd0);

    // Asynchronous reset with both stages occupied.
    out_ready = 1'b0;
    send(32'h3F800000, 32'h3F800000, 1'b0);
    send(32'h40000000, 32'h40000000, 1'b1);
    in_valid = 1'b0;
    check("pre_rst_out_valid", 128'(out_valid), 128'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 128'(out_valid), 128'd0);
    check("mid_rst_in_ready", 128'(in_ready), 128'd0);
    exp_q.delete();
    hold_v = 1'b0;
    #10 rst = 1'b0;
    #1;
    check("post_rst_in_ready_lo", 128'(in_ready), 128'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready_hi", 128'(in_ready), 128'd1);
    send(32'h3F800000, 32'h3F000000, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_cycle1", 128'(out_valid), 128'd0);
    @(negedge clk);
    check("lat_cycle2", 128'(out_valid), 128'd1);
    repeat (3) @(posedge clk);
    #1;
    check("final_queue_empty", 128'(exp_q.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
